uart_tx_frame_gen: RTL and testbench

//   Parametrised 16550-class UART transmit serialiser, next generation of the TX shifter.

---
 rtl/uart_tx_frame_gen.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_gen.sv
// UART transmit serialiser: pops bytes from the TX FIFO and emits start/data/parity/stop frames on tx.
// Latency: pop and the start bit begin on the first baud_pulse with data and CTS; tx lags the internal bit by 1 clk.
// Backpressure: a frame starts only when fifo_empty=0 and cts_n=0; frames in flight always complete; FIFO read is a 1-clk pop.
module uart_tx_frame_gen #(
  parameter int OVS    = 16,   // baud_pulse ticks per bit time; even, >= 4
  parameter int DATA_W = 8     // FIFO width; must be >= 8, frames use the low 5..8 bits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_pulse,
  input  logic [1:0]        wls,
  input  logic              stb,
  input  logic              pen,
  input  logic              eps,
  input  logic              sticky_parity,
  input  logic              set_break,
  input  logic              cts_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] din,
  output logic              pop,
  output logic              tx,
  output logic              sreg_empty,
  output logic              busy
);

  localparam int CNT_W = $clog2(2 * OVS);
  localparam logic [CNT_W-1:0] TC_ONE  = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] TC_HALF = CNT_W'((3 * OVS) / 2 - 1);
  localparam logic [CNT_W-1:0] TC_TWO  = CNT_W'(2 * OVS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;    // shifted right as bits go out
  logic [1:0]       wls_q, wls_d;
  logic             pen_q, pen_d;
  logic             stb_q, stb_d;
  logic             par_q, par_d;      // parity bit resolved when the frame is loaded
  logic             tx_data_q, tx_data_d;
  logic             pop_q, pop_d;
  logic             tx_q;

  logic [7:0]       load_mask;
  logic             load_par;
  logic [2:0]       last_bit;
  logic [CNT_W-1:0] term_cnt;
  logic             bit_end;
  logic             can_load;

  // Frame-independent decode: parity of the incoming byte and terminal count of the current bit
  always_comb begin
    case (wls)
      2'b00:   load_mask = 8'h1F;
      2'b01:   load_mask = 8'h3F;
      2'b10:   load_mask = 8'h7F;
      default: load_mask = 8'hFF;
    endcase
    if (sticky_parity) load_par = ~eps;
    else if (eps)      load_par = ^(din[7:0] & load_mask);
    else               load_par = ~^(din[7:0] & load_mask);

    last_bit = 3'd4 + {1'b0, wls_q};
    if (state_q != S_STOP || !stb_q) term_cnt = TC_ONE;
    else if (wls_q == 2'b00)         term_cnt = TC_HALF;
    else                             term_cnt = TC_TWO;
    bit_end  = (tick_q == term_cnt);
    can_load = !fifo_empty && !cts_n;
  end

  // Next-state logic; everything except pop advances only on baud_pulse
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    wls_d     = wls_q;
    pen_d     = pen_q;
    stb_d     = stb_q;
    par_d     = par_q;
    tx_data_d = tx_data_q;
    pop_d     = 1'b0;
    if (baud_pulse) begin
      if (state_q != S_IDLE) tick_d = bit_end ? '0 : tick_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (can_load) state_d = S_START;
        end
        S_START: begin
          if (bit_end) begin
            state_d   = S_DATA;
            bit_d     = 3'd0;
            tx_data_d = data_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == last_bit) begin
              state_d   = pen_q ? S_PARITY : S_STOP;
              tx_data_d = pen_q ? par_q : 1'b1;
            end else begin
              bit_d     = bit_q + 3'd1;
              data_d    = data_q >> 1;
              tx_data_d = data_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_d   = S_STOP;
            tx_data_d = 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state_d   = can_load ? S_START : S_IDLE;
            tx_data_d = 1'b1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          tx_data_d = 1'b1;
        end
      endcase
      // Frame load from idle or straight out of a finished stop bit (no idle gap)
      if (state_d == S_START && (state_q == S_IDLE || state_q == S_STOP)) begin
        pop_d     = 1'b1;
        data_d    = din[7:0];
        wls_d     = wls;
        pen_d     = pen;
        stb_d     = stb;
        par_d     = load_par;
        tick_d    = '0;
        bit_d     = 3'd0;
        tx_data_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; tx is the registered line with break override
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= 3'd0;
      data_q    <= 8'h00;
      wls_q     <= 2'b00;
      pen_q     <= 1'b0;
      stb_q     <= 1'b0;
      par_q     <= 1'b0;
      tx_data_q <= 1'b1;
      pop_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      wls_q     <= wls_d;
      pen_q     <= pen_d;
      stb_q     <= stb_d;
      par_q     <= par_d;
      tx_data_q <= tx_data_d;
      pop_q     <= pop_d;
      tx_q      <= tx_data_q & ~set_break;
    end
  end

  assign pop        = pop_q;
  assign tx         = tx_q;
  assign sreg_empty = (state_q == S_IDLE);
  assign busy       = ~sreg_empty;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: OVS=16, baud_pulse every 6 clk, FIFO modelled as a queue.
module tb_uart_tx_frame_gen;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_pulse = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sticky_parity = 1'b0;
  logic       set_break = 1'b0;
  logic       cts_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] din = 8'h00;
  logic       pop, tx, sreg_empty, busy;

  int checks = 0;
  int passes = 0;
  int pop_cnt = 0;
  int bcnt = 0;
  logic [7:0] fq[$];

  uart_tx_frame_gen #(.OVS(OVS), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .wls(wls), .stb(stb), .pen(pen),
    .eps(eps), .sticky_parity(sticky_parity), .set_break(set_break), .cts_n(cts_n),
    .fifo_empty(fifo_empty), .din(din), .pop(pop), .tx(tx), .sreg_empty(sreg_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Baud generator: one-clk pulse every 6 clocks, driven away from the active edge
  always @(negedge clk) begin
    bcnt = (bcnt == 5) ? 0 : bcnt + 1;
    baud_pulse = (bcnt == 0);
  end

  // FIFO model: head on din, pop removes it
  always @(negedge clk) begin
    if (pop === 1'b1) begin
      pop_cnt = pop_cnt + 1;
      if (fq.size() > 0) fq.delete(0);
    end
    fifo_empty = (fq.size() == 0);
    din = (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // Line value for the tick that started at the next baud_pulse
  task automatic sample_tick(output logic v);
    do @(posedge clk); while (baud_pulse !== 1'b1);
    @(posedge clk);
    #1;
    v = tx;
  endtask

  task automatic wait_start(input string nm);
    logic v;
    bit found = 0;
    for (int i = 0; i < 300; i++) begin
      sample_tick(v);
      if (v === 1'b0) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) $display("FAIL %s start: no start bit seen within 300 ticks, required one", nm);
    else passes++;
  endtask

  task automatic seg(input string nm, input logic lvl, input int n, input logic want_busy);
    logic v;
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      sample_tick(v);
      if (v !== lvl || busy !== want_busy) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL %s: %0d of %0d ticks wrong (tx/busy), required level %b busy %b", nm, bad, n, lvl, want_busy);
    else passes++;
  endtask

  // Called with the first start-bit tick already consumed
  task automatic check_frame(input string nm, input logic [7:0] b, input int n, input bit has_par,
                             input logic par, input int stop_ticks, input bit follow);
    logic v;
    seg($sformatf("%s start", nm), 1'b0, OVS - 1, 1'b1);
    for (int i = 0; i < n; i++) seg($sformatf("%s data%0d", nm, i), b[i], OVS, 1'b1);
    if (has_par) seg($sformatf("%s parity", nm), par, OVS, 1'b1);
    seg($sformatf("%s stop", nm), 1'b1, stop_ticks, 1'b1);
    sample_tick(v);
    checks++;
    if (follow) begin
      if (v !== 1'b0 || busy !== 1'b1) $display("FAIL %s next start: tx=%b busy=%b, required tx=0 busy=1", nm, v, busy);
      else passes++;
    end else begin
      if (v !== 1'b1 || sreg_empty !== 1'b1 || busy !== 1'b0)
        $display("FAIL %s end: tx=%b sreg_empty=%b busy=%b, required 1 1 0", nm, v, sreg_empty, busy);
      else passes++;
    end
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic s, input logic p, input logic e, input logic sp);
    wls = w; stb = s; pen = p; eps = e; sticky_parity = sp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL reset tx: %b, required 1", tx); else passes++;
    checks++; if (pop !== 1'b0) $display("FAIL reset pop: %b, required 0", pop); else passes++;
    checks++; if (sreg_empty !== 1'b1) $display("FAIL reset sreg_empty: %b, required 1", sreg_empty); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset busy: %b, required 0", busy); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_8n1();
    int p0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    p0 = pop_cnt;
    fq.push_back(8'h13);
    wait_start("8N1");
    checks++; if (pop_cnt - p0 != 1) $display("FAIL 8N1 pop at start: %0d pops, required 1", pop_cnt - p0); else passes++;
    check_frame("8N1", 8'h13, 8, 0, 1'b0, 16, 0);
    checks++; if (pop_cnt - p0 != 1) $display("FAIL 8N1 pop width: %0d pop clks, required 1", pop_cnt - p0); else passes++;
  endtask

  task automatic test_parity_2stop();
    set_cfg(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    fq.push_back(8'h13);
    wait_start("8E2");
    check_frame("8E2", 8'h13, 8, 1, 1'b1, 32, 0);
    eps = 1'b0;
    fq.push_back(8'h13);
    wait_start("8O2");
    check_frame("8O2", 8'h13, 8, 1, 1'b0, 32, 0);
  endtask

  task automatic test_5bit_1p5();
    set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    fq.push_back(8'hFF);
    wait_start("5b FF");
    check_frame("5b FF", 8'hFF, 5, 0, 1'b0, 24, 0);
    fq.push_back(8'hE0);
    wait_start("5b E0");
    check_frame("5b E0", 8'hE0, 5, 0, 1'b0, 24, 0);
  endtask

  task automatic test_stick_parity();
    set_cfg(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    fq.push_back(8'h07);
    wait_start("stick1");
    check_frame("stick1", 8'h07, 8, 1, 1'b0, 16, 0);
    eps = 1'b0;
    fq.push_back(8'h07);
    wait_start("stick0");
    set_cfg(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    check_frame("stick0", 8'h07, 8, 1, 1'b1, 16, 0);
  endtask

  task automatic test_flow();
    int p0;
    logic v;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b1;
    p0 = pop_cnt;
    fq.push_back(8'h5A);
    seg("cts hold", 1'b1, 20, 1'b0);
    checks++; if (pop_cnt != p0) $display("FAIL cts hold pop: %0d pops, required 0", pop_cnt - p0); else passes++;
    cts_n = 1'b0;
    sample_tick(v);
    checks++; if (v !== 1'b0) $display("FAIL cts release start: tx=%b, required 0", v); else passes++;
    check_frame("cts frame", 8'h5A, 8, 0, 1'b0, 16, 0);
  endtask

  task automatic test_back_to_back();
    int p0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    p0 = pop_cnt;
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    wait_start("b2b");
    check_frame("b2b first", 8'hA5, 8, 0, 1'b0, 16, 1);
    check_frame("b2b second", 8'h3C, 8, 0, 1'b0, 16, 0);
    checks++; if (pop_cnt - p0 != 2) $display("FAIL b2b pops: %0d, required 2", pop_cnt - p0); else passes++;
  endtask

  task automatic test_break();
    logic v;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fq.push_back(8'hFF);
    wait_start("break");
    for (int i = 0; i < 20; i++) sample_tick(v);
    checks++; if (v !== 1'b1) $display("FAIL break pre: tx=%b, required 1", v); else passes++;
    set_break = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (tx !== 1'b0) $display("FAIL break assert: tx=%b, required 0", tx); else passes++;
    seg("break hold", 1'b0, 5, 1'b1);
    set_break = 1'b0;
    seg("break resume", 1'b1, 160 - 26, 1'b1);
    sample_tick(v);
    checks++;
    if (sreg_empty !== 1'b1 || v !== 1'b1) $display("FAIL break frame end: sreg_empty=%b tx=%b, required 1 1", sreg_empty, v);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    logic v;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fq.push_back(8'h00);
    wait_start("rst mid");
    for (int i = 0; i < 20; i++) sample_tick(v);
    p0 = pop_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || sreg_empty !== 1'b1 || pop !== 1'b0)
      $display("FAIL rst mid: tx=%b busy=%b sreg_empty=%b pop=%b, required 1 0 1 0", tx, busy, sreg_empty, pop);
    else passes++;
    rst = 1'b0;
    seg("rst idle", 1'b1, 40, 1'b0);
    checks++; if (pop_cnt != p0) $display("FAIL rst re-pop: %0d pops, required 0", pop_cnt - p0); else passes++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_2stop();
    test_5bit_1p5();
    test_stick_parity();
    test_flow();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
